// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: data-bus records and pipeline bundles.
// Packages common (bus) and pipes (stage records, FSM states, op helpers).
package common;
  localparam int XLEN      = 64;
  localparam int BUS_BYTES = 8;
  localparam int OFF_W     = $clog2(BUS_BYTES);

  typedef enum logic [1:0] {
    MSIZE1, MSIZE2, MSIZE4, MSIZE8
  } msize_t;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      addr;
    msize_t               size;
    logic [BUS_BYTES-1:0] strobe;
    logic [XLEN-1:0]      data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;
endpackage

package pipes;
  import common::*;

  typedef enum logic [3:0] {
    OP_ALU,
    OP_LB, OP_LH, OP_LW, OP_LD,
    OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef enum logic [1:0] {
    MIS_NONE  = 2'd0,
    MIS_LOAD  = 2'd1,
    MIS_STORE = 2'd2
  } mis_t;

  typedef struct packed {
    mis_t misalign;
    logic regwrite;
    op_t  op;
  } ctl_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [4:0]      dst;
    logic [31:0]     instr;
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] rd;
  } exec_data_t;

  typedef struct packed {
    ctl_t            ctl;
    logic [4:0]      dst;
    logic [31:0]     instr;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] addr;
  } mem_data_t;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } mem_state_t;

  function automatic logic is_load(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD,
                      OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_store(op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic is_mem(op_t op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic is_signed_ld(op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD};
  endfunction

  function automatic msize_t op_size(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return MSIZE1;
      OP_LH, OP_LHU, OP_SH: return MSIZE2;
      OP_LW, OP_LWU, OP_SW: return MSIZE4;
      default:              return MSIZE8;
    endcase
  endfunction

  function automatic logic misaligned(msize_t sz,
                                      logic [OFF_W-1:0] off);
    case (sz)
      MSIZE1:  return 1'b0;
      MSIZE2:  return off[0];
      MSIZE4:  return |off[1:0];
      default: return |off;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Handshake bundle around the memory stage: execute in, writeback out,
// and the data-bus request/response pair.
interface mem_stage_if;
  import common::*;
  import pipes::*;

  logic       in_valid;
  logic       in_ready;
  exec_data_t dataE;
  logic       out_valid;
  logic       out_ready;
  mem_data_t  dataM;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport slave (
    input  in_valid, dataE, out_ready, dresp,
    output in_ready, out_valid, dataM, dreq
  );

  modport master (
    output in_valid, dataE, out_ready, dresp,
    input  in_ready, out_valid, dataM, dreq
  );
endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store strobe/data placement and load
// extraction with sign or zero extension.
module mem_align
  import common::*;
(
  input  logic [OFF_W-1:0]     st_off_i,
  input  msize_t               st_size_i,
  input  logic [XLEN-1:0]      st_wdata_i,
  output logic [BUS_BYTES-1:0] st_strb_o,
  output logic [XLEN-1:0]      st_data_o,
  input  logic [OFF_W-1:0]     ld_off_i,
  input  msize_t               ld_size_i,
  input  logic                 ld_signed_i,
  input  logic [XLEN-1:0]      ld_raw_i,
  output logic [XLEN-1:0]      ld_data_o
);
  logic [BUS_BYTES-1:0] base;
  logic [XLEN-1:0]      sh;
  logic                 s;

  always_comb begin
    base = '0;
    unique case (st_size_i)
      MSIZE1: base = 8'h01;
      MSIZE2: base = 8'h03;
      MSIZE4: base = 8'h0F;
      MSIZE8: base = 8'hFF;
    endcase
    st_strb_o = base << st_off_i;
    st_data_o = st_wdata_i << {st_off_i, 3'b000};
  end

  always_comb begin
    sh        = ld_raw_i >> {ld_off_i, 3'b000};
    s         = 1'b0;
    ld_data_o = sh;
    unique case (ld_size_i)
      MSIZE1: begin
        s         = ld_signed_i & sh[7];
        ld_data_o = {{56{s}}, sh[7:0]};
      end
      MSIZE2: begin
        s         = ld_signed_i & sh[15];
        ld_data_o = {{48{s}}, sh[15:0]};
      end
      MSIZE4: begin
        s         = ld_signed_i & sh[31];
        ld_data_o = {{32{s}}, sh[31:0]};
      end
      MSIZE8: ld_data_o = sh;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one outstanding bus access at a time.
// Optional MEM_MISALIGN_CHECK_EN faults misaligned accesses without a request.
module mem_stage
  import common::*;
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);
  mem_state_t state_q, state_d;
  mem_data_t  data_q, data_d, entry;

  logic [BUS_BYTES-1:0] strb_q, strb_d, st_strb;
  logic [XLEN-1:0]      wdata_q, wdata_d, st_data, ld_data;

  logic   ready, accept, cap;
  logic   e_mem, e_mis, e_st, e_ld;
  msize_t e_size, q_size;
  logic   q_signed;

  assign e_size   = op_size(bus.dataE.ctl.op);
  assign e_mem    = is_mem(bus.dataE.ctl.op);
  assign e_st     = is_store(bus.dataE.ctl.op);
  assign e_ld     = is_load(bus.dataE.ctl.op);
  assign q_size   = op_size(data_q.ctl.op);
  assign q_signed = is_signed_ld(data_q.ctl.op);

`ifdef MEM_MISALIGN_CHECK_EN
  assign e_mis = e_mem &&
    misaligned(e_size, bus.dataE.aluout[OFF_W-1:0]);
`else
  assign e_mis = 1'b0;
`endif

  assign ready  = (state_q == IDLE) ||
                  (state_q == DONE && bus.out_ready);
  assign accept = bus.in_valid && ready;

  mem_align u_align (
    .st_off_i    (bus.dataE.aluout[OFF_W-1:0]),
    .st_size_i   (e_size),
    .st_wdata_i  (bus.dataE.rd),
    .st_strb_o   (st_strb),
    .st_data_o   (st_data),
    .ld_off_i    (data_q.addr[OFF_W-1:0]),
    .ld_size_i   (q_size),
    .ld_signed_i (q_signed),
    .ld_raw_i    (bus.dresp.data),
    .ld_data_o   (ld_data)
  );

  // Record built at accept; loads fill result when data returns.
  always_comb begin
    entry              = '0;
    entry.ctl          = bus.dataE.ctl;
    entry.ctl.misalign = MIS_NONE;
    entry.dst          = bus.dataE.dst;
    entry.instr        = bus.dataE.instr;
    entry.addr         = bus.dataE.aluout;
    entry.result       = e_mem ? '0 : bus.dataE.aluout;
    if (e_st) entry.ctl.regwrite = 1'b0;
    if (e_mis) begin
      entry.result       = bus.dataE.aluout;
      entry.ctl.regwrite = 1'b0;
      if (e_ld) entry.ctl.misalign = MIS_LOAD;
      else      entry.ctl.misalign = MIS_STORE;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    cap     = 1'b0;
    unique case (state_q)
      REQ: begin
        if (bus.dresp.addr_ok && bus.dresp.data_ok) begin
          state_d = DONE;
          cap     = 1'b1;
        end else if (bus.dresp.addr_ok) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.dresp.data_ok) begin
          state_d = DONE;
          cap     = 1'b1;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = (e_mem && !e_mis) ? REQ : DONE;
      data_d  = entry;
      strb_d  = (e_st && !e_mis) ? st_strb : '0;
      wdata_d = e_st ? st_data : '0;
    end else if (cap && is_load(data_q.ctl.op)) begin
      data_d.result = ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.dataM     = data_q;

  always_comb begin
    bus.dreq        = '0;
    bus.dreq.valid  = (state_q == REQ);
    bus.dreq.addr   = data_q.addr;
    bus.dreq.size   = q_size;
    bus.dreq.strobe = strb_q;
    bus.dreq.data   = wdata_q;
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-lane model.
// Define MEM_MISALIGN_CHECK_EN to exercise the misalignment fault path.
module tb_mem_stage;
  import common::*;
  import pipes::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  op_t mem_ops [11] = '{OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU,
                        OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW, OP_SD};

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int nbytes(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_LWU, OP_SW: return 4;
      default:              return 8;
    endcase
  endfunction

  function automatic logic [63:0] m_load(op_t op, logic [63:0] a,
                                         logic [63:0] raw);
    int n   = nbytes(op);
    int off = int'(a % 8);
    logic [63:0] v, mask;
    v    = raw >> (8 * off);
    mask = (n == 8) ? '1 : (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if ((op inside {OP_LB, OP_LH, OP_LW, OP_LD}) && v[8*n-1])
      v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] m_strb(op_t op, logic [63:0] a);
    int m = (1 << nbytes(op)) - 1;
    return 8'((m << int'(a % 8)) & 255);
  endfunction

  function automatic logic [63:0] m_wdata(logic [63:0] rd,
                                          logic [63:0] a);
    return rd << (8 * int'(a % 8));
  endfunction

  function automatic exec_data_t make_e(op_t op, logic [63:0] a,
                                        logic [63:0] rd);
    exec_data_t e;
    e              = '0;
    e.ctl.op       = op;
    e.ctl.regwrite = 1'b1;
    e.ctl.misalign = MIS_NONE;
    e.dst          = 5'($urandom_range(1, 31));
    e.instr        = $urandom;
    e.aluout       = a;
    e.rd           = rd;
    return e;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.dataE     = '0;
    bus.out_ready = 1'b1;
    bus.dresp     = '0;
  endtask

  // Drives one memory op through the bus protocol and reports observations.
  task automatic mem_txn(input exec_data_t e, input int stall,
                         input int gap, input logic [63:0] raw,
                         output dbus_req_t req0, output bit stable,
                         output bit wait_low, output int lat,
                         output mem_data_t m);
    bus.dataE    = e;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.dataE    = '0;
    req0         = bus.dreq;
    stable       = 1'b1;
    wait_low     = 1'b1;
    for (int i = 0; i < stall; i++) begin
      bus.dresp.data = r64();
      step();
      if (bus.dreq !== req0) stable = 1'b0;
    end
    bus.dresp.addr_ok = 1'b1;
    if (gap == 0) begin
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = raw;
    end
    step();
    bus.dresp = '0;
    if (gap > 0) begin
      for (int i = 1; i < gap; i++) begin
        if (bus.dreq.valid !== 1'b0) wait_low = 1'b0;
        step();
      end
      if (bus.dreq.valid !== 1'b0) wait_low = 1'b0;
      bus.dresp.data_ok = 1'b1;
      bus.dresp.data    = raw;
      step();
      bus.dresp = '0;
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    m = bus.dataM;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3 reset = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.dreq.valid !== 1'b0) begin failures++; $display("FAIL reset_dreq_valid got=%b exp=0", bus.dreq.valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.dataM !== '0) begin failures++; $display("FAIL reset_dataM got=%h exp=0", bus.dataM); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu();
    logic [63:0] v;
    bit          dv;
    for (int i = 0; i < 4; i++) begin
      v            = (i == 0) ? 64'h5 : r64();
      bus.dataE    = make_e(OP_ALU, v, r64());
      bus.in_valid = 1'b1;
      dv           = bus.dreq.valid;
      step();
      bus.in_valid = 1'b0;
      dv           = dv | bus.dreq.valid;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL alu_out_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.dataM.result !== v) begin failures++; $display("FAIL alu_result[%0d] got=%h exp=%h", i, bus.dataM.result, v); end
      checks++; if (bus.dataM.ctl.regwrite !== 1'b1) begin failures++; $display("FAIL alu_regwrite[%0d] got=%b exp=1", i, bus.dataM.ctl.regwrite); end
      step();
      dv = dv | bus.dreq.valid;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL alu_retire[%0d] got=%b exp=0", i, bus.out_valid); end
      checks++; if (dv !== 1'b0) begin failures++; $display("FAIL alu_no_dreq[%0d] got=%b exp=0", i, dv); end
    end
  endtask

  task automatic test_store_sb();
    dbus_req_t r; bit st, wl; int lat; mem_data_t m;
    mem_txn(make_e(OP_SB, 64'h1003, 64'hAB), 3, 0, r64(),
            r, st, wl, lat, m);
    checks++; if (r.valid !== 1'b1) begin failures++; $display("FAIL sb_valid got=%b exp=1", r.valid); end
    checks++; if (r.strobe !== 8'h08) begin failures++; $display("FAIL sb_strobe got=%h exp=08", r.strobe); end
    checks++; if (r.data !== 64'h00000000AB000000) begin failures++; $display("FAIL sb_data got=%h exp=00000000ab000000", r.data); end
    checks++; if (r.addr !== 64'h1003) begin failures++; $display("FAIL sb_addr got=%h exp=1003", r.addr); end
    checks++; if (r.size !== MSIZE1) begin failures++; $display("FAIL sb_size got=%0d exp=0", r.size); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL sb_stable got=%b exp=1", st); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL sb_latency got=%0d exp=0", lat); end
    checks++; if (m.result !== 64'h0) begin failures++; $display("FAIL sb_result got=%h exp=0", m.result); end
    checks++; if (m.ctl.regwrite !== 1'b0) begin failures++; $display("FAIL sb_regwrite got=%b exp=0", m.ctl.regwrite); end
  endtask

  task automatic test_load_byte();
    dbus_req_t r; bit st, wl; int lat; mem_data_t m;
    logic [63:0] raw = 64'h0080_0000_0000_0000;
    mem_txn(make_e(OP_LB, 64'h2006, r64()), 0, 0, raw,
            r, st, wl, lat, m);
    checks++; if (m.result !== 64'hFFFFFFFFFFFFFF80) begin failures++; $display("FAIL lb_result got=%h exp=ffffffffffffff80", m.result); end
    checks++; if (r.strobe !== 8'h00) begin failures++; $display("FAIL lb_strobe got=%h exp=00", r.strobe); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL lb_latency got=%0d exp=0", lat); end
    mem_txn(make_e(OP_LBU, 64'h2006, r64()), 1, 0, raw,
            r, st, wl, lat, m);
    checks++; if (m.result !== 64'h80) begin failures++; $display("FAIL lbu_result got=%h exp=80", m.result); end
    checks++; if (m.ctl.regwrite !== 1'b1) begin failures++; $display("FAIL lbu_regwrite got=%b exp=1", m.ctl.regwrite); end
  endtask

  task automatic test_load_latency();
    dbus_req_t r; bit st, wl; int lat; mem_data_t m;
    logic [63:0] raw;
    for (int g = 2; g >= 0; g -= 2) begin
      raw = r64();
      mem_txn(make_e(OP_LW, 64'h3004, r64()), 0, g, raw,
              r, st, wl, lat, m);
      checks++; if (lat !== 0) begin failures++; $display("FAIL lw_latency gap=%0d got=%0d exp=0", g, lat); end
      checks++; if (wl !== 1'b1) begin failures++; $display("FAIL lw_wait_valid gap=%0d got=%b exp=1", g, wl); end
      checks++; if (m.result !== m_load(OP_LW, 64'h3004, raw)) begin failures++; $display("FAIL lw_result gap=%0d got=%h exp=%h", g, m.result, m_load(OP_LW, 64'h3004, raw)); end
    end
  endtask

  task automatic test_random();
    dbus_req_t r; bit st, wl; int lat; mem_data_t m;
    logic [63:0] a, rd, raw, er;
    op_t op;
    for (int i = 0; i < 16; i++) begin
      op  = mem_ops[$urandom_range(0, 10)];
      a   = r64() & ~64'(nbytes(op) - 1);
      rd  = r64();
      raw = r64();
      mem_txn(make_e(op, a, rd), $urandom_range(0, 2),
              $urandom_range(0, 2), raw, r, st, wl, lat, m);
      er = (nbytes(op) > 0 && op inside {OP_SB, OP_SH, OP_SW, OP_SD})
           ? 64'h0 : m_load(op, a, raw);
      checks++; if (m.result !== er) begin failures++; $display("FAIL rnd_result[%0d] op=%s got=%h exp=%h", i, op.name(), m.result, er); end
      checks++; if (r.addr !== a || r.valid !== 1'b1) begin failures++; $display("FAIL rnd_addr[%0d] got=%h/%b exp=%h/1", i, r.addr, r.valid, a); end
      checks++; if (lat !== 0 || st !== 1'b1 || wl !== 1'b1) begin failures++; $display("FAIL rnd_timing[%0d] lat=%0d stable=%b waitlow=%b exp=0/1/1", i, lat, st, wl); end
      if (op inside {OP_SB, OP_SH, OP_SW, OP_SD}) begin
        checks++; if (r.strobe !== m_strb(op, a)) begin failures++; $display("FAIL rnd_strobe[%0d] got=%h exp=%h", i, r.strobe, m_strb(op, a)); end
        checks++; if (r.data !== m_wdata(rd, a)) begin failures++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, r.data, m_wdata(rd, a)); end
      end else begin
        checks++; if (r.strobe !== 8'h00) begin failures++; $display("FAIL rnd_ld_strobe[%0d] got=%h exp=00", i, r.strobe); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] v1 = r64(), v2 = r64();
    mem_data_t   snap;
    bit          stab = 1'b1, rlow = 1'b1;
    bus.out_ready = 1'b0;
    bus.dataE     = make_e(OP_ALU, v1, 64'h0);
    bus.in_valid  = 1'b1;
    step();
    bus.dataE = make_e(OP_ALU, v2, 64'h0);
    snap      = bus.dataM;
    checks++; if (bus.out_valid !== 1'b1 || snap.result !== v1) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/%h", bus.out_valid, snap.result, v1); end
    for (int i = 0; i < 4; i++) begin
      if (bus.in_ready !== 1'b0) rlow = 1'b0;
      step();
      if (bus.dataM !== snap || bus.out_valid !== 1'b1) stab = 1'b0;
    end
    checks++; if (stab !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", stab); end
    checks++; if (rlow !== 1'b1) begin failures++; $display("FAIL bp_in_ready_low got=%b exp=1", rlow); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.dataM.result !== v2) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/%h", bus.out_valid, bus.dataM.result, v2); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v            = r64();
      bus.dataE    = make_e(OP_ALU, v, 64'h0);
      bus.in_valid = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.dataM.result !== v) begin failures++; $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h", i, bus.out_valid, bus.dataM.result, v); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.dataE    = make_e(OP_LW, 64'h4000, 64'h0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.dreq.valid !== 1'b1) begin failures++; $display("FAIL rmid_req got=%b exp=1", bus.dreq.valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.dreq.valid !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b/%b exp=0/0", bus.dreq.valid, bus.out_valid); end
    step();
    reset = 1'b1;
    bus.dresp.addr_ok = 1'b1;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data    = r64();
    step();
    bus.dresp = '0;
    checks++; if (bus.out_valid !== 1'b0 || bus.dreq.valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_discard got=%b/%b/%b exp=0/0/1", bus.out_valid, bus.dreq.valid, bus.in_ready); end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign();
    op_t         ops [2] = '{OP_LW, OP_SH};
    logic [63:0] as  [2] = '{64'h1002, 64'h1001};
    mis_t        ef  [2] = '{MIS_LOAD, MIS_STORE};
    for (int i = 0; i < 2; i++) begin
      bus.dataE    = make_e(ops[i], as[i], r64());
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      checks++; if (bus.dreq.valid !== 1'b0) begin failures++; $display("FAIL mis_no_req[%0d] got=%b exp=0", i, bus.dreq.valid); end
      checks++; if (bus.out_valid !== 1'b1 || bus.dataM.ctl.misalign !== ef[i]) begin failures++; $display("FAIL mis_flag[%0d] got=%b/%0d exp=1/%0d", i, bus.out_valid, bus.dataM.ctl.misalign, ef[i]); end
      checks++; if (bus.dataM.result !== as[i]) begin failures++; $display("FAIL mis_result[%0d] got=%h exp=%h", i, bus.dataM.result, as[i]); end
      step();
    end
  endtask
`else
  task automatic test_misalign();
    dbus_req_t r; bit st, wl; int lat; mem_data_t m;
    logic [63:0] raw = r64();
    mem_txn(make_e(OP_LW, 64'h1002, r64()), 0, 0, raw,
            r, st, wl, lat, m);
    checks++; if (r.valid !== 1'b1 || r.addr !== 64'h1002) begin failures++; $display("FAIL mis_issued got=%b/%h exp=1/1002", r.valid, r.addr); end
    checks++; if (m.ctl.misalign !== MIS_NONE) begin failures++; $display("FAIL mis_flag_zero got=%0d exp=0", m.ctl.misalign); end
    checks++; if (m.result !== m_load(OP_LW, 64'h1002, raw)) begin failures++; $display("FAIL mis_result got=%h exp=%h", m.result, m_load(OP_LW, 64'h1002, raw)); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store_sb();
    test_load_byte();
    test_load_latency();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
